rob: RTL

//  Reorder buffer at the far end of the rename/decode stage. Hands free ROB indices
//  to the renamer and captures each renamed op's arch regs and old aliases.

---
 rtl/rob_if.sv | 34 +++
 rtl/rob.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rob_if.sv
// Reorder buffer port bundle: allocation offers/requests, completion ports,
// registered commit slots and occupancy status.
interface rob_if #(
    parameter int IDX_W    = 5,
    parameter int DISP_W   = 4,
    parameter int CMPL_W   = 4,
    parameter int COMMIT_W = 3
);
    logic [DISP_W*IDX_W-1:0]  alloc_entries;
    logic [DISP_W-1:0]        alloc_ready;
    logic [DISP_W-1:0]        alloc_valid;
    logic [DISP_W*8-1:0]      alloc_arch_regs;
    logic [DISP_W*10-1:0]     alloc_old_aliases;
    logic [CMPL_W-1:0]        cmpl_valid;
    logic [CMPL_W*IDX_W-1:0]  cmpl_idx;
    logic [COMMIT_W-1:0]      commit_valid;
    logic [COMMIT_W*8-1:0]    commit_arch_regs;
    logic [COMMIT_W*10-1:0]   commit_free_regs;
    logic [IDX_W:0]           count;
    logic                     empty;
    logic                     full;

    modport master (
        input  alloc_entries, alloc_ready, commit_valid, commit_arch_regs,
               commit_free_regs, count, empty, full,
        output alloc_valid, alloc_arch_regs, alloc_old_aliases, cmpl_valid, cmpl_idx
    );

    modport slave (
        output alloc_entries, alloc_ready, commit_valid, commit_arch_regs,
               commit_free_regs, count, empty, full,
        input  alloc_valid, alloc_arch_regs, alloc_old_aliases, cmpl_valid, cmpl_idx
    );
endinterface

// File: rtl/rob.sv
// Reorder buffer: offers free indices to the renamer, marks entries done on completion,
// and retires the oldest done entries in order, returning their old aliases.
module rob #(
    parameter int DEPTH    = 32,
    parameter int IDX_W    = 5,
    parameter int DISP_W   = 4,
    parameter int CMPL_W   = 4,
    parameter int COMMIT_W = 3
) (
    input  logic clk,
    input  logic rst,
    rob_if.slave bus
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [IDX_W-1:0]             head_q, head_d;
    logic [IDX_W-1:0]             tail_q, tail_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0]             done_q, done_d;
    logic [DEPTH-1:0][7:0]        arch_q, arch_d;
    logic [DEPTH-1:0][9:0]        alias_q, alias_d;
    logic [COMMIT_W-1:0]          commit_valid_q, commit_valid_d;
    logic [COMMIT_W*8-1:0]        commit_arch_q, commit_arch_d;
    logic [COMMIT_W*10-1:0]       commit_free_q, commit_free_d;

    logic [DISP_W-1:0]            ready_vec;
    logic [DISP_W-1:0][IDX_W-1:0] lane_idx;
    logic [DISP_W-1:0]            lane_take;
    logic                         alloc_run;
    logic [CNT_W-1:0]             n_alloc;
    logic [COMMIT_W-1:0][IDX_W-1:0] slot_idx;
    logic [COMMIT_W-1:0]          slot_ret;
    logic                         ret_run;
    logic [CNT_W-1:0]             n_commit;

    // Offers and readiness depend only on registered tail/count.
    always_comb begin
        for (int k = 0; k < DISP_W; k++) begin
            lane_idx[k]  = tail_q + IDX_W'(DISP_W - 1 - k);
            ready_vec[k] = (DEPTH_C - count_q) >= CNT_W'(DISP_W - k);
        end
    end

    // Lanes are accepted oldest-first; the first gap drops every younger lane.
    always_comb begin
        alloc_run = 1'b1;
        n_alloc   = '0;
        lane_take = '0;
        for (int k = DISP_W - 1; k >= 0; k--) begin
            alloc_run    = alloc_run & bus.alloc_valid[k] & ready_vec[k];
            lane_take[k] = alloc_run;
            if (alloc_run) begin
                n_alloc = n_alloc + ONE_C;
            end
        end
    end

    // Offset j from head retires only if every older offset retires too.
    always_comb begin
        ret_run  = 1'b1;
        n_commit = '0;
        slot_ret = '0;
        for (int j = 0; j < COMMIT_W; j++) begin
            slot_idx[j] = head_q + IDX_W'(j);
            ret_run     = ret_run & valid_q[slot_idx[j]] & done_q[slot_idx[j]];
            slot_ret[j] = ret_run;
            if (ret_run) begin
                n_commit = n_commit + ONE_C;
            end
        end
    end

    // Update order gives completion < retirement < allocation precedence.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        arch_d  = arch_q;
        alias_d = alias_q;
        for (int p = 0; p < CMPL_W; p++) begin
            if (bus.cmpl_valid[p] && valid_q[bus.cmpl_idx[p*IDX_W +: IDX_W]]) begin
                done_d[bus.cmpl_idx[p*IDX_W +: IDX_W]] = 1'b1;
            end
        end
        for (int j = 0; j < COMMIT_W; j++) begin
            if (slot_ret[j]) begin
                valid_d[slot_idx[j]] = 1'b0;
                done_d[slot_idx[j]]  = 1'b0;
            end
        end
        for (int k = 0; k < DISP_W; k++) begin
            if (lane_take[k]) begin
                valid_d[lane_idx[k]] = 1'b1;
                done_d[lane_idx[k]]  = 1'b0;
                arch_d[lane_idx[k]]  = bus.alloc_arch_regs[k*8 +: 8];
                alias_d[lane_idx[k]] = bus.alloc_old_aliases[k*10 +: 10];
            end
        end
        head_d  = head_q + n_commit[IDX_W-1:0];
        tail_d  = tail_q + n_alloc[IDX_W-1:0];
        count_d = count_q + n_alloc - n_commit;
    end

    // Highest slot carries the head entry; unused slots stay zero.
    always_comb begin
        commit_valid_d = '0;
        commit_arch_d  = '0;
        commit_free_d  = '0;
        for (int j = 0; j < COMMIT_W; j++) begin
            if (slot_ret[j]) begin
                commit_valid_d[COMMIT_W-1-j]             = 1'b1;
                commit_arch_d[(COMMIT_W-1-j)*8 +: 8]     = arch_q[slot_idx[j]];
                commit_free_d[(COMMIT_W-1-j)*10 +: 10]   = alias_q[slot_idx[j]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            valid_q        <= '0;
            done_q         <= '0;
            commit_valid_q <= '0;
            commit_arch_q  <= '0;
            commit_free_q  <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            valid_q        <= valid_d;
            done_q         <= done_d;
            commit_valid_q <= commit_valid_d;
            commit_arch_q  <= commit_arch_d;
            commit_free_q  <= commit_free_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        arch_q  <= arch_d;
        alias_q <= alias_d;
    end

    assign bus.alloc_entries    = lane_idx;
    assign bus.alloc_ready      = ready_vec;
    assign bus.commit_valid     = commit_valid_q;
    assign bus.commit_arch_regs = commit_arch_q;
    assign bus.commit_free_regs = commit_free_q;
    assign bus.count            = count_q;
    assign bus.empty            = (count_q == '0);
    assign bus.full             = (count_q == DEPTH_C);

endmodule
